// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Round-robin arbiter sharing one external memory port between num_proc tiles.
// A granted tile keeps the bus while its request stays high; every change of
// owner passes through one all-idle turnaround cycle so that no two tiles ever
// drive the shared bus in the same cycle.
//
// Ports:
//   in_clk          clock, rising edge
//   in_reset        asynchronous, active-low reset
//   in_request      bit i = tile i requests / holds the bus
//   out_grant       one-hot or zero grant vector (registered)
//   out_grant_valid OR of out_grant (registered)
//   out_grant_id    index of current owner; keeps the last owner while idle
//   out_timeout     one-cycle pulse when the watchdog revokes a grant
//
// Build option: define MEM_ARB_WATCHDOG_EN to limit each grant to max_hold
// cycles. Without it out_timeout is tied low and grants last indefinitely.

module mem_bus_arbiter #(
    parameter int unsigned num_proc = 4,
    parameter int unsigned max_hold = 64,
    parameter int unsigned id_width = (num_proc > 1) ? $clog2(num_proc) : 1
) (
    input  logic                in_clk,
    input  logic                in_reset,
    input  logic [num_proc-1:0] in_request,
    output logic [num_proc-1:0] out_grant,
    output logic                out_grant_valid,
    output logic [id_width-1:0] out_grant_id,
    output logic                out_timeout
);

    if (num_proc == 0 || max_hold == 0) begin : g_bad_param
        $error("mem_bus_arbiter: num_proc and max_hold must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_t;

    state_t              r_state;
    logic [num_proc-1:0] r_grant;
    logic                r_grant_valid;
    logic [id_width-1:0] r_grant_id;
    logic [id_width-1:0] r_last;

    logic [id_width-1:0] w_idx;
    logic [id_width-1:0] w_winner;
    logic                w_any;
    logic [num_proc-1:0] w_onehot;
    logic                w_release;
    logic                w_expire;

    // Scan from r_last+1 upward modulo num_proc. The loop walks the distance
    // downward so the nearest requester is the last one written.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = num_proc; k >= 1; k--) begin
            w_idx = id_width'((int'(r_last) + k) % int'(num_proc));
            if (in_request[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < num_proc; i++) begin
            w_onehot[i] = (w_winner == id_width'(i));
        end
    end

    assign w_release = !in_request[r_grant_id];

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int unsigned HoldW = $clog2(max_hold + 1);

    logic [HoldW-1:0] r_hold;
    logic             r_timeout;

    // Counter holds (grant cycles - 1); hitting max_hold-1 means the grant
    // has already been high for max_hold cycles by this edge.
    assign w_expire = (r_hold == HoldW'(max_hold - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last        <= id_width'(num_proc - 1);
`ifdef MEM_ARB_WATCHDOG_EN
            r_hold        <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
`ifdef MEM_ARB_WATCHDOG_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                StIdle, StTurn: begin
                    if (w_any) begin
                        r_state       <= StGrant;
                        r_grant       <= w_onehot;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_winner;
`ifdef MEM_ARB_WATCHDOG_EN
                        r_hold        <= '0;
`endif
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StGrant: begin
                    if (w_release || w_expire) begin
                        r_state       <= StTurn;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_last        <= r_grant_id;
`ifdef MEM_ARB_WATCHDOG_EN
                        // A plain release on the same edge is not a timeout.
                        r_timeout     <= !w_release;
`endif
                    end
`ifdef MEM_ARB_WATCHDOG_EN
                    else begin
                        r_hold <= r_hold + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state       <= StIdle;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_grant       = r_grant;
    assign out_grant_valid = r_grant_valid;
    assign out_grant_id    = r_grant_id;
`ifdef MEM_ARB_WATCHDOG_EN
    assign out_timeout     = r_timeout;
`else
    assign out_timeout     = 1'b0;
`endif

endmodule
